hud_draw_sequencer: RTL
=======================

# hud_draw_sequencer

Parametrised successor to the game's fixed four-digit display controller. It scans `NUM_SLOTS` on-screen symbol slots round-robin and detects slots whose symbol changed since they were last drawn. For each such slot it issues one draw request to the symbol draw module through a go/done handshake. Sits between the game-state/timer logic, which supplies slot contents, and the draw module, which supplies pixel plotting.

## Interface
- `NUM_SLOTS`, default 8: number of symbol slots; must be ≥2.
- `IDX_W`, default 3: slot index width; must satisfy 2^IDX_W ≥ NUM_SLOTS.
- `SYM_W`, default 6: symbol code width.
- `X_W`, default 8: X coordinate width.
- `Y_W`, default 7: Y coordinate width.
- `SCALE_W`, default 3: scale code width.
- `TIMEOUT`, default 4095: maximum cycles to wait for `done_sym`; must be ≥1.

Ports:
- `clk` in 1: single clock. All logic is rising-edge.
- `resetn` in 1: asynchronous, active-low reset.
- `enable` in 1: when low, no new draw is started. A draw already in flight completes.
- `force_all` in 1: a one-cycle pulse that marks every slot for redraw.
- `sym_in` in NUM_SLOTS*SYM_W: packed slot symbols. Slot i occupies bits [i*SYM_W +: SYM_W].
- `x_in` in NUM_SLOTS*X_W: packed slot X positions.
- `y_in` in NUM_SLOTS*Y_W: packed slot Y positions.
- `scale_in` in NUM_SLOTS*SCALE_W: packed slot scales.
- `done_sym` in 1: draw-complete pulse from the draw module.
- `go_draw` out 1: one-cycle draw request.
- `sym_out` out SYM_W: latched symbol of the current request.
- `x_out` out X_W: latched X position of the current request.
- `y_out` out Y_W: latched Y position of the current request.
- `scale_out` out SCALE_W: latched scale of the current request.
- `slot_out` out IDX_W: index of the current request.
- `busy` out 1: high from `go_draw` until the request completes or aborts.
- `pass_done` out 1: one-cycle pulse when the scan pointer wraps from slot NUM_SLOTS-1 to slot 0.
- `timeout_err` out 1: sticky flag, set on a handshake timeout, cleared only by reset.

## Operation
- Per-slot state:
  - `shadow[i]` (SYM_W): the last symbol successfully drawn in slot i.
  - `force[i]` (1 bit): redraw requested.
- Slot i is dirty when `force[i]`, or when `sym_in[i] != shadow[i]`.
- Reset: all `force` bits are set, `shadow` is cleared to 0, the pointer is 0 and the FSM is in SCAN. The first pass therefore draws every slot.
- FSM states:
  - SCAN, slot-examine branch: when `enable`=1, examine slot `ptr`. If it is dirty, latch its `sym`/`x`/`y`/`scale`/index into the output registers and go to ISSUE. If it is clean, advance `ptr` and stay in SCAN.
  - SCAN, disabled branch: when `enable`=0, hold `ptr` and stay in SCAN.
  - ISSUE: assert `go_draw` for exactly one cycle, set `busy`, clear the timeout counter, then go to WAIT.
  - WAIT, completion branch: on `done_sym`=1, write the latched symbol into `shadow[slot]`, clear `force[slot]`, advance `ptr`, clear `busy`, then go to SCAN.
  - WAIT, timeout branch: if the counter reaches TIMEOUT before `done_sym`, set `timeout_err`, leave `shadow`/`force` unchanged, advance `ptr`, clear `busy`, then go to SCAN. The slot stays dirty and is retried on a later pass.
- Pointer advance is modulo NUM_SLOTS. `pass_done` pulses in the cycle the advance goes from NUM_SLOTS-1 to 0, on every wrap path: clean skip, completion or timeout.
- The shadow stores the latched symbol, not the live input. If `sym_in[slot]` changes during a draw, the slot is still dirty afterwards and is redrawn on the next pass.
- `force_all` sets all `force` bits. If `force_all` coincides with completion of slot k, `force[k]` ends the cycle set (the set wins).
- `done_sym` is ignored outside WAIT.

## Timing
- Reset values: `go_draw`=0, `busy`=0, `pass_done`=0, `timeout_err`=0, `sym_out`/`x_out`/`y_out`/`scale_out`/`slot_out`=0.
- Clean slot: 1 cycle per slot. A full clean pass takes NUM_SLOTS cycles.
- Dirty slot: examined in cycle t, `go_draw` high in cycle t+1, and WAIT begins in t+2.
- `done_sym` is sampled only from t+2 onward. A `done_sym` arriving in the same cycle as `go_draw` is ignored.
- After `done_sym` in cycle d, the FSM is in SCAN in d+1 and the next slot is examined in d+1.
- All request outputs stay stable from `go_draw` until the cycle after completion or abort.
- Timeout: the abort fires in the WAIT cycle where the counter equals TIMEOUT, i.e. TIMEOUT cycles after WAIT entry.
- Deasserting `enable` in WAIT does not abort the draw.
- Asserting `resetn`=0 at any time returns all state to reset values immediately. A pending draw is abandoned with no completion.

## Test plan
- Reset, then `enable`=1 with NUM_SLOTS=8, and `done_sym` returned 3 cycles after each `go_draw` -> 8 `go_draw` pulses with `slot_out` 0..7 in order, then `pass_done` on the wrap. The next pass has no `go_draw`, and `pass_done` recurs every 8 cycles.
- After a clean pass, change slot 5's symbol from 6'h03 to 6'h11 -> exactly one `go_draw` with `slot_out`=5 and `sym_out`=6'h11. Afterwards `shadow[5]`=6'h11.
- Change slot 2's symbol while slot 2 is in WAIT -> completion with the old `sym_out`, then on the next pass a second `go_draw` for slot 2 with the new value.
- Pulse `force_all` in the same cycle as `done_sym` for slot 4 -> slot 4 is redrawn on the next pass, along with all other slots.
- Never return `done_sym`, with TIMEOUT=15 -> `timeout_err` rises 15 cycles after WAIT entry, `busy` falls, and the scan moves to the next slot. The aborted slot is requested again on the following pass.
- Drop `enable` mid-WAIT, then assert `resetn`=0 mid-WAIT -> the first draw completes normally and no new `go_draw` occurs while `enable`=0. Under reset, all outputs go to 0 asynchronously, and after release all 8 slots are redrawn.

Source files
------------

// File: rtl/hud_draw_sequencer.sv
// Round-robin HUD slot scanner: finds slots whose symbol changed since last drawn and
// issues one go/done draw request per dirty slot, with a bounded wait on the draw module.
module hud_draw_sequencer #(
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned IDX_W     = 3,
  parameter int unsigned SYM_W     = 6,
  parameter int unsigned X_W       = 8,
  parameter int unsigned Y_W       = 7,
  parameter int unsigned SCALE_W   = 3,
  parameter int unsigned TIMEOUT   = 4095
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         enable,
  input  logic                         force_all,
  input  logic [NUM_SLOTS*SYM_W-1:0]   sym_in,
  input  logic [NUM_SLOTS*X_W-1:0]     x_in,
  input  logic [NUM_SLOTS*Y_W-1:0]     y_in,
  input  logic [NUM_SLOTS*SCALE_W-1:0] scale_in,
  input  logic                         done_sym,
  output logic                         go_draw,
  output logic [SYM_W-1:0]             sym_out,
  output logic [X_W-1:0]               x_out,
  output logic [Y_W-1:0]               y_out,
  output logic [SCALE_W-1:0]           scale_out,
  output logic [IDX_W-1:0]             slot_out,
  output logic                         busy,
  output logic                         pass_done,
  output logic                         timeout_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StScan, StIssue, StWait} state_e;

  state_e               state_q;
  logic [NUM_SLOTS-1:0] force_q;
  logic [SYM_W-1:0]     shadow_q [NUM_SLOTS];
  logic [IDX_W-1:0]     ptr_q;
  logic [CntW-1:0]      cnt_q;
  logic                 go_draw_q, busy_q, pass_done_q, timeout_err_q;
  logic [SYM_W-1:0]     sym_q;
  logic [X_W-1:0]       x_q;
  logic [Y_W-1:0]       y_q;
  logic [SCALE_W-1:0]   scale_q;
  logic [IDX_W-1:0]     slot_q;

  logic [SYM_W-1:0]     cur_sym;
  logic [X_W-1:0]       cur_x;
  logic [Y_W-1:0]       cur_y;
  logic [SCALE_W-1:0]   cur_scale;
  logic                 dirty, wrap;
  logic [IDX_W-1:0]     ptr_nxt, slot_nxt;
  logic                 slot_wrap;

  always_comb begin
    cur_sym   = sym_in[int'(ptr_q)*SYM_W +: SYM_W];
    cur_x     = x_in[int'(ptr_q)*X_W +: X_W];
    cur_y     = y_in[int'(ptr_q)*Y_W +: Y_W];
    cur_scale = scale_in[int'(ptr_q)*SCALE_W +: SCALE_W];
    dirty     = force_q[ptr_q] | (cur_sym != shadow_q[ptr_q]);
    wrap      = (ptr_q == IDX_W'(NUM_SLOTS - 1));
    ptr_nxt   = wrap ? '0 : ptr_q + 1'b1;
    // Completion and abort advance from the latched slot, which equals ptr_q in WAIT.
    slot_wrap = (slot_q == IDX_W'(NUM_SLOTS - 1));
    slot_nxt  = slot_wrap ? '0 : slot_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= StScan;
      force_q       <= '1;
      for (int i = 0; i < int'(NUM_SLOTS); i++) shadow_q[i] <= '0;
      ptr_q         <= '0;
      cnt_q         <= '0;
      go_draw_q     <= 1'b0;
      busy_q        <= 1'b0;
      pass_done_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      sym_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      scale_q       <= '0;
      slot_q        <= '0;
    end else begin
      go_draw_q   <= 1'b0;
      pass_done_q <= 1'b0;
      unique case (state_q)
        StScan: begin
          if (enable) begin
            if (dirty) begin
              sym_q     <= cur_sym;
              x_q       <= cur_x;
              y_q       <= cur_y;
              scale_q   <= cur_scale;
              slot_q    <= ptr_q;
              go_draw_q <= 1'b1;
              busy_q    <= 1'b1;
              state_q   <= StIssue;
            end else begin
              ptr_q       <= ptr_nxt;
              pass_done_q <= wrap;
            end
          end
        end
        StIssue: begin
          cnt_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (done_sym) begin
            shadow_q[slot_q] <= sym_q;
            force_q[slot_q]  <= 1'b0;
            ptr_q            <= slot_nxt;
            pass_done_q      <= slot_wrap;
            busy_q           <= 1'b0;
            state_q          <= StScan;
          end else if (cnt_q == CntW'(TIMEOUT)) begin
            // Slot stays dirty so a later pass retries it.
            timeout_err_q <= 1'b1;
            ptr_q         <= slot_nxt;
            pass_done_q   <= slot_wrap;
            busy_q        <= 1'b0;
            state_q       <= StScan;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StScan;
      endcase
      // Placed last so a coincident completion cannot clear a fresh redraw request.
      if (force_all) force_q <= '1;
    end
  end

  assign go_draw     = go_draw_q;
  assign busy        = busy_q;
  assign pass_done   = pass_done_q;
  assign timeout_err = timeout_err_q;
  assign sym_out     = sym_q;
  assign x_out       = x_q;
  assign y_out       = y_q;
  assign scale_out   = scale_q;
  assign slot_out    = slot_q;

endmodule
